// File: rtl/usb_rx_controller.sv
// rtl/usb_rx_controller.sv - USB full-speed receive sequencer: SYNC check, byte framing, FIFO write strobes, error flagging
module usb_rx_controller #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic [6:0] rx_bytes
);

    typedef enum logic [3:0] {
        IDLE, SYNC_RCV, SYNC_CHK, DATA_RCV, STORE,
        EOP_WAIT, ERR_WAIT, EOP_ERR, EIDLE
    } state_t;

    localparam logic [6:0] MAX_B = 7'(MAX_BYTES);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_bytes_q, rx_bytes_d;
    logic       ovf_q, ovf_d;
    logic       eighth_bit;
    logic       eop_sample;

    assign eighth_bit = shift_enable && (bit_cnt_q == 3'd7);
    assign eop_sample = eop && shift_enable;
    assign rx_bytes   = rx_bytes_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_bytes_q <= 7'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_bytes_q <= rx_bytes_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_bytes_d = rx_bytes_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE, EIDLE: begin
                if (d_edge) begin
                    state_d    = SYNC_RCV;
                    bit_cnt_d  = 3'd0;
                    rx_bytes_d = 7'd0;
                    ovf_d      = 1'b0;
                end
            end
            SYNC_RCV: begin
                if (shift_enable) bit_cnt_d = bit_cnt_q + 3'd1;
                if (eighth_bit)      state_d = SYNC_CHK;
                else if (eop_sample) state_d = EOP_ERR;
            end
            SYNC_CHK: begin
                state_d = (rcv_data == SYNC_BYTE) ? DATA_RCV : ERR_WAIT;
            end
            DATA_RCV: begin
                if (shift_enable) bit_cnt_d = bit_cnt_q + 3'd1;
                // eop outranks a completed byte: a byte ending on SE0 is not trusted
                if (eop_sample) begin
                    state_d = (bit_cnt_q == 3'd0) ? EOP_WAIT : EOP_ERR;
                end else if (eighth_bit) begin
                    if (ovf_q) begin
                        state_d = ERR_WAIT;
                    end else begin
                        state_d   = STORE;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            STORE: begin
                state_d = DATA_RCV;
                if (rx_bytes_q != MAX_B) rx_bytes_d = rx_bytes_q + 7'd1;
                ovf_d = ((rx_bytes_q + 7'd1) == MAX_B);
            end
            EOP_WAIT: if (d_edge)     state_d = IDLE;
            ERR_WAIT: if (eop_sample) state_d = EOP_ERR;
            EOP_ERR:  if (d_edge)     state_d = EIDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        rcving   = 1'b0;
        w_enable = 1'b0;
        r_error  = 1'b0;
        case (state_q)
            SYNC_RCV, SYNC_CHK, DATA_RCV, EOP_WAIT: rcving = 1'b1;
            STORE: begin
                rcving   = 1'b1;
                w_enable = 1'b1;
            end
            ERR_WAIT, EOP_ERR: begin
                rcving  = 1'b1;
                r_error = 1'b1;
            end
            EIDLE:   r_error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usb_rx_controller.sv
// tb/tb_usb_rx_controller.sv - scoreboard bench for usb_rx_controller (MAX_BYTES 64 and 2 instances)
module tb_usb_rx_controller;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic [7:0] rcv_data;

    logic       rcving_a, w_enable_a, r_error_a;
    logic [6:0] rx_bytes_a;
    logic       rcving_b, w_enable_b, r_error_b;
    logic [6:0] rx_bytes_b;

    logic       use_b;
    logic       m_rcving, m_wen, m_rerr;
    logic [6:0] m_bytes;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    usb_rx_controller #(.SYNC_BYTE(8'h80), .MAX_BYTES(64)) dut_a (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .rcv_data(rcv_data),
        .rcving(rcving_a), .w_enable(w_enable_a), .r_error(r_error_a), .rx_bytes(rx_bytes_a)
    );

    usb_rx_controller #(.SYNC_BYTE(8'h80), .MAX_BYTES(2)) dut_b (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .rcv_data(rcv_data),
        .rcving(rcving_b), .w_enable(w_enable_b), .r_error(r_error_b), .rx_bytes(rx_bytes_b)
    );

    assign m_rcving = use_b ? rcving_b   : rcving_a;
    assign m_wen    = use_b ? w_enable_b : w_enable_a;
    assign m_rerr   = use_b ? r_error_b  : r_error_a;
    assign m_bytes  = use_b ? rx_bytes_b : rx_bytes_a;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_wen === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got data %02h at cycle %0d expected none", rcv_data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("write_data", int'(rcv_data), int'(e.data));
                    chk("write_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic tick(input logic de, input logic e, input logic se);
        d_edge = de;
        eop = e;
        shift_enable = se;
        @(posedge clk);
        #1;
        d_edge = 1'b0;
        eop = 1'b0;
        shift_enable = 1'b0;
    endtask

    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push);
        exp_t e;
        rcv_data = b;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (i == 7 && push) begin
                e.data = b;
                e.cyc  = cyc;
                sb.push_back(e);
            end
            tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        d_edge = 1'b0;
        eop = 1'b0;
        shift_enable = 1'b0;
        rcv_data = 8'h00;
        use_b = 1'b0;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rcving", m_rcving, 0);
        chk("reset_wen", m_wen, 0);
        chk("reset_rerr", m_rerr, 0);
        chk("reset_bytes", m_bytes, 0);
        n_rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);

        // clean two-byte packet
        tick(1'b1, 1'b0, 1'b0);
        chk("clean_rcving_start", m_rcving, 1);
        send_byte(8'h80, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk("clean_eopwait_rcving", m_rcving, 1);
        chk("clean_eopwait_rerr", m_rerr, 0);
        tick(1'b1, 1'b0, 1'b0);
        chk("clean_rcving_end", m_rcving, 0);
        chk("clean_bytes", m_bytes, 2);
        chk("clean_rerr", m_rerr, 0);
        chk("clean_pending", sb.size(), 0);

        // bad SYNC
        tick(1'b1, 1'b0, 1'b0);
        send_byte(8'h81, 1'b0);
        chk("badsync_rerr", m_rerr, 1);
        tick(1'b0, 1'b1, 1'b1);
        chk("badsync_eoperr_rerr", m_rerr, 1);
        chk("badsync_eoperr_rcving", m_rcving, 1);
        tick(1'b1, 1'b0, 1'b0);
        chk("badsync_eidle_rerr", m_rerr, 1);
        chk("badsync_eidle_rcving", m_rcving, 0);

        // recovery from EIDLE
        tick(1'b1, 1'b0, 1'b0);
        chk("recover_rerr", m_rerr, 0);
        chk("recover_rcving", m_rcving, 1);
        chk("recover_bytes_clr", m_bytes, 0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h5A, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        chk("recover_bytes", m_bytes, 1);
        chk("recover_end_rerr", m_rerr, 0);

        // eop in the middle of a byte
        tick(1'b1, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        rcv_data = 8'h07;
        shifts(3);
        tick(1'b0, 1'b1, 1'b1);
        chk("midbyte_rerr", m_rerr, 1);
        chk("midbyte_bytes", m_bytes, 0);
        tick(1'b1, 1'b0, 1'b0);
        chk("midbyte_eidle_rerr", m_rerr, 1);

        // overflow on the MAX_BYTES=2 instance
        use_b = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rcv_data = 8'h33;
        shifts(7);
        tick(1'b0, 1'b0, 1'b1);
        chk("ovf_rerr", m_rerr, 1);
        chk("ovf_wen", m_wen, 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("ovf_bytes", m_bytes, 2);
        chk("ovf_rerr_hold", m_rerr, 1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        chk("ovf_eidle_bytes", m_bytes, 2);
        chk("ovf_pending", sb.size(), 0);

        // asynchronous reset mid-packet
        tick(1'b1, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        rcv_data = 8'hC3;
        shifts(5);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_rcving", m_rcving, 0);
        chk("arst_wen", m_wen, 0);
        chk("arst_rerr", m_rerr, 0);
        chk("arst_bytes", m_bytes, 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("arst_restart_rcving", m_rcving, 1);
        chk("arst_restart_rerr", m_rerr, 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("final_pending", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
